// File: rtl/dmx_pkg.sv
// Shared DMX constants, arbiter state type and the universe one-hot decoder.
package dmx_pkg;

    localparam int DMX_PORTS      = 4;
    localparam int DMX_MAX_CH     = 512;
    localparam int DMX_ADDR_W     = 10;
    localparam int DMX_START_ADDR = 0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } arb_state_e;

    function automatic logic [DMX_PORTS-1:0] port_onehot(input logic [1:0] port);
        port_onehot = 4'b0001 << port;
    endfunction

endpackage

// File: rtl/dmx_rr_arbiter.sv
// Pure round-robin picker: first asserted request searching upward from last+1.
module dmx_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   winner_o
);

    logic             found_s;
    logic [IDX_W-1:0] idx_s;

    // rotating priority search, first hit after last_i wins
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (!found_s && req_i[idx_s]) begin
                found_s        = 1'b1;
                grant_o[idx_s] = 1'b1;
                winner_o       = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/dmx_write_arbiter.sv
// Round-robin arbiter for the shared EBR port-B write path of four DMX universes.
// Optional blackout sweep compiled in with `define DMX_ARB_BLACKOUT_EN.
module dmx_write_arbiter
    import dmx_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int CH_COUNT = DMX_MAX_CH,
    parameter int ADDR_W   = DMX_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_port,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0]      req_data,
    output logic [DMX_PORTS-1:0]      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_data,
    output logic                      err_range,
    input  logic                      blackout_req,
    input  logic [1:0]                blackout_port,
    output logic                      blackout_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [DMX_PORTS-1:0]    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic                    err_q, err_d;
    logic [NUM_REQ-1:0]      grant_s;
    logic [NUM_REQ-1:0]      ready_s;
    logic [IDX_W-1:0]        winner_s;
    logic [1:0]              sel_port_s;
    logic [ADDR_W-1:0]       sel_addr_s;
    logic [7:0]              sel_data_s;
    logic                    in_range_s;
`ifdef DMX_ARB_BLACKOUT_EN
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic [1:0]              bo_port_q, bo_port_d;
`else
    logic                    unused_bo_s;
    assign unused_bo_s = ^{blackout_req, blackout_port};
`endif

    dmx_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i    (req_valid),
        .last_i   (last_q),
        .grant_o  (grant_s),
        .winner_o (winner_s)
    );

    assign sel_port_s = req_port[2*int'(winner_s) +: 2];
    assign sel_addr_s = req_addr[ADDR_W*int'(winner_s) +: ADDR_W];
    assign sel_data_s = req_data[8*int'(winner_s) +: 8];
    // start code slot is reserved, so the window is START+1..CH_COUNT
    assign in_range_s = (sel_addr_s > ADDR_W'(DMX_START_ADDR)) &&
                        (sel_addr_s <= ADDR_W'(CH_COUNT));

    // next-state: arbitration in IDLE, one zero write per cycle in SWEEP
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        ready_s   = '0;
`ifdef DMX_ARB_BLACKOUT_EN
        cnt_d     = cnt_q;
        bo_port_d = bo_port_q;
`endif
        case (state_q)
            IDLE: begin
                ready_s = grant_s;
                if (|grant_s) begin
                    last_d = winner_s;
                    if (in_range_s) begin
                        wr_en_d   = port_onehot(sel_port_s);
                        wr_addr_d = sel_addr_s;
                        wr_data_d = sel_data_s;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    last_d = last_q;
                end
`ifdef DMX_ARB_BLACKOUT_EN
                if (blackout_req) begin
                    state_d   = SWEEP;
                    cnt_d     = '0;
                    bo_port_d = blackout_port;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            SWEEP: begin
`ifdef DMX_ARB_BLACKOUT_EN
                wr_en_d   = port_onehot(bo_port_q);
                wr_addr_d = cnt_q;
                wr_data_d = 8'h00;
                if (cnt_q == ADDR_W'(CH_COUNT)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and registered write-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            err_q     <= 1'b0;
`ifdef DMX_ARB_BLACKOUT_EN
            cnt_q     <= '0;
            bo_port_q <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
`ifdef DMX_ARB_BLACKOUT_EN
            cnt_q     <= cnt_d;
            bo_port_q <= bo_port_d;
`endif
        end
    end

    // ready is combinational but must read zero while reset is held
    assign req_ready     = ready_s & {NUM_REQ{rst_n}};
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign err_range     = err_q;
`ifdef DMX_ARB_BLACKOUT_EN
    assign blackout_busy = (state_q == SWEEP);
`else
    assign blackout_busy = 1'b0;
`endif

endmodule

// File: tb/tb_dmx_write_arbiter.sv
// Randomized + directed bench for dmx_write_arbiter against a queue-based reference model.
module tb_dmx_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int CH      = 512;
    localparam int AW      = 10;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_port = '0;
    logic [AW*NUM_REQ-1:0] req_addr = '0;
    logic [8*NUM_REQ-1:0]  req_data = '0;
    logic [3:0]            wr_en;
    logic [AW-1:0]         wr_addr;
    logic [7:0]            wr_data;
    logic                  err_range;
    logic                  blackout_req = 1'b0;
    logic [1:0]            blackout_port = 2'd0;
    logic                  blackout_busy;

    dmx_write_arbiter #(.NUM_REQ(NUM_REQ), .CH_COUNT(CH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_port(req_port), .req_addr(req_addr), .req_data(req_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err_range(err_range),
        .blackout_req(blackout_req), .blackout_port(blackout_port),
        .blackout_busy(blackout_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] port;
        int         addr;
    } sw_t;

    // reference model: last winner, held write bus, pending blackout writes
    int                 m_last = NUM_REQ - 1;
    logic [AW-1:0]      m_addr = '0;
    logic [7:0]         m_data = 8'h00;
    sw_t                sweep_q[$];
    logic [NUM_REQ-1:0] obs_ready;
    int                 n_checks = 0;
    int                 n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [1:0] p,
                           input logic [AW-1:0] a, input logic [7:0] d);
        req_valid[r]         = v;
        req_port[2*r +: 2]   = p;
        req_addr[AW*r +: AW] = a;
        req_data[8*r +: 8]   = d;
    endtask

    task automatic model_reset();
        m_last = NUM_REQ - 1;
        m_addr = '0;
        m_data = 8'h00;
        sweep_q.delete();
    endtask

    // one clock: inputs already driven after negedge; check ready, then registered outputs
    task automatic step();
        int            w;
        logic [NUM_REQ-1:0] exp_ready;
        logic [3:0]    x_en;
        logic          x_err;
        logic [AW-1:0] a;
        sw_t           e;
        bit            sweeping;
        #1;
        sweeping  = (sweep_q.size() != 0);
        w         = -1;
        exp_ready = '0;
        if (!sweeping) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int r;
                r = (m_last + k) % NUM_REQ;
                if (w < 0 && req_valid[r]) w = r;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        obs_ready = req_ready;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        x_en  = 4'b0000;
        x_err = 1'b0;
        if (sweeping) begin
            e      = sweep_q.pop_front();
            x_en   = 4'b0001 << e.port;
            m_addr = AW'(e.addr);
            m_data = 8'h00;
        end else begin
            if (w >= 0) begin
                m_last = w;
                a = req_addr[AW*w +: AW];
                if (a >= 1 && a <= CH) begin
                    x_en   = 4'b0001 << req_port[2*w +: 2];
                    m_addr = a;
                    m_data = req_data[8*w +: 8];
                end else begin
                    x_err = 1'b1;
                end
            end
`ifdef DMX_ARB_BLACKOUT_EN
            if (blackout_req) begin
                for (int c = 0; c <= CH; c++) sweep_q.push_back('{blackout_port, c});
            end
`endif
        end
        @(posedge clk);
        #1;
        check_eq("wr_en", 32'(wr_en), 32'(x_en));
        check_eq("wr_addr", 32'(wr_addr), 32'(m_addr));
        check_eq("wr_data", 32'(wr_data), 32'(m_data));
        check_eq("err_range", 32'(err_range), 32'(x_err));
        check_eq("blackout_busy", 32'(blackout_busy), 32'(sweep_q.size() != 0));
        @(negedge clk);
    endtask

    initial begin
        int grant_seq[$];
        int busy_cnt;
        int zero_wr;
        bit seen;

        // reset state, with requests pending
        req_valid = '1;
        #3;
        check_eq("rst_ready", 32'(req_ready), 32'(0));
        check_eq("rst_wr_en", 32'(wr_en), 32'(0));
        check_eq("rst_wr_addr", 32'(wr_addr), 32'(0));
        check_eq("rst_wr_data", 32'(wr_data), 32'(0));
        check_eq("rst_err", 32'(err_range), 32'(0));
        check_eq("rst_busy", 32'(blackout_busy), 32'(0));
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single request
        set_req(0, 1'b1, 2'd2, AW'(1), 8'h80);
        step();
        check_eq("single_ready", 32'(obs_ready), 32'(3'b001));
        check_eq("single_wr_en", 32'(wr_en), 32'(4'b0100));
        check_eq("single_wr_addr", 32'(wr_addr), 32'(1));
        check_eq("single_wr_data", 32'(wr_data), 32'(8'h80));
        set_req(0, 1'b0, 2'd0, AW'(0), 8'h00);
        step();

        // fairness after a fresh reset
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b1, 2'(r), AW'(10 + r), 8'(r + 1));
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("fair_strobe", 32'(|wr_en), 32'(1));
            for (int r = 0; r < NUM_REQ; r++) if (obs_ready[r]) grant_seq.push_back(r);
        end
        for (int i = 0; i < 6; i++) check_eq("fair_order", 32'(grant_seq[i]), 32'(i % 3));
        req_valid = '0;

        // range errors, then top of range
        set_req(1, 1'b1, 2'd3, AW'(0), 8'h11);
        step();
        check_eq("addr0_en", 32'(wr_en), 32'(0));
        check_eq("addr0_err", 32'(err_range), 32'(1));
        set_req(1, 1'b1, 2'd3, AW'(513), 8'h22);
        step();
        check_eq("addr513_en", 32'(wr_en), 32'(0));
        check_eq("addr513_err", 32'(err_range), 32'(1));
        set_req(1, 1'b1, 2'd3, AW'(512), 8'h33);
        step();
        check_eq("addr512_en", 32'(wr_en), 32'(4'b1000));
        check_eq("addr512_err", 32'(err_range), 32'(0));
        req_valid = '0;
        step();

`ifdef DMX_ARB_BLACKOUT_EN
        // blackout port 1 with requester 1 held valid
        set_req(1, 1'b1, 2'd1, AW'(7), 8'h33);
        blackout_req  = 1'b1;
        blackout_port = 2'd1;
        busy_cnt = 0;
        zero_wr  = 0;
        for (int i = 0; i < 516; i++) begin
            step();
            blackout_req = 1'b0;
            if (blackout_busy) busy_cnt++;
            if (wr_en == 4'b0010 && wr_data == 8'h00) zero_wr++;
        end
        check_eq("bo_busy_len", 32'(busy_cnt), 32'(CH + 1));
        check_eq("bo_writes", 32'(zero_wr), 32'(CH + 1));
        req_valid = '0;
        step();

        // same-cycle blackout and requester write to the same universe
        set_req(0, 1'b1, 2'd2, AW'(5), 8'hAA);
        blackout_req  = 1'b1;
        blackout_port = 2'd2;
        step();
        blackout_req = 1'b0;
        req_valid    = '0;
        check_eq("simul_wr_en", 32'(wr_en), 32'(4'b0100));
        check_eq("simul_wr_addr", 32'(wr_addr), 32'(5));
        check_eq("simul_wr_data", 32'(wr_data), 32'(8'hAA));
        seen = 1'b0;
        for (int i = 0; i < 515; i++) begin
            step();
            if (wr_en == 4'b0100 && wr_addr == AW'(5) && wr_data == 8'h00) seen = 1'b1;
        end
        check_eq("simul_overwrite", 32'(seen), 32'(1));

        // reset in the middle of a sweep
        blackout_req  = 1'b1;
        blackout_port = 2'd3;
        step();
        blackout_req = 1'b0;
        for (int i = 0; i < 101; i++) step();
        set_req(0, 1'b1, 2'd0, AW'(3), 8'h5A);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_en", 32'(wr_en), 32'(0));
        check_eq("mid_rst_addr", 32'(wr_addr), 32'(0));
        check_eq("mid_rst_busy", 32'(blackout_busy), 32'(0));
        check_eq("mid_rst_ready", 32'(req_ready), 32'(0));
        #1;
        rst_n = 1'b1;
        step();
        check_eq("post_rst_ready", 32'(obs_ready), 32'(3'b001));
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("post_rst_quiet", 32'(wr_en), 32'(0));
        end
`endif

        // randomized traffic, occasional blackout requests
        for (int i = 0; i < 2500; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                set_req(r, 1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                        AW'($urandom_range(0, 540)), 8'($urandom_range(0, 255)));
            end
            blackout_req  = ($urandom_range(0, 399) == 0);
            blackout_port = 2'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
